// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue -- instruction fetch queue between the icache/BPU and decode.
//
// A circular FIFO of DEPTH entries. Each entry holds the fetch PC, the
// instruction word, the BPU prediction (taken + target) and the fetch
// exception flag with its 7-bit cause. The fetch side presents up to two
// entries per cycle and decode consumes up to two per cycle. All 2-slot
// buses are packed {slot1, slot0}.
//
// Optional feature macro: INST_QUEUE_PERF_EN
//   When defined, adds the full_stall_cnt output, a saturating count of
//   cycles in which fetch offered entries while the queue refused them.
//
// Ports
//   clk              in   clock, all state on rising edge
//   rst              in   synchronous active-high reset (overrides flush)
//   flush            in   discard all entries
//   in_valid[1:0]    in   fetch slot valid (00, 01, 11; 10 is ignored)
//   in_pc[63:0]      in   fetch PCs
//   in_inst[63:0]    in   instruction words
//   in_pred_taken[1:0]  in   BPU predicted taken
//   in_pred_addr[63:0]  in   BPU predicted targets
//   in_excp[1:0]     in   fetch exception flags
//   in_excp_cause[13:0] in   7-bit exception cause per slot
//   in_ready         out  two free entries available (registered count only)
//   deq_num[1:0]     in   entries consumed by decode (3 treated as 2)
//   out_valid[1:0]   out  head / head+1 valid
//   out_pc, out_inst, out_pred_taken, out_pred_addr, out_excp,
//   out_excp_cause   out  head / head+1 entry fields
//   count            out  current occupancy (0..DEPTH)
//   full_stall_cnt   out  stall cycle counter (INST_QUEUE_PERF_EN only)
// ---------------------------------------------------------------------------
module inst_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [1:0]               in_valid,
    input  logic [63:0]              in_pc,
    input  logic [63:0]              in_inst,
    input  logic [1:0]               in_pred_taken,
    input  logic [63:0]              in_pred_addr,
    input  logic [1:0]               in_excp,
    input  logic [13:0]              in_excp_cause,
    output logic                     in_ready,
    input  logic [1:0]               deq_num,
    output logic [1:0]               out_valid,
    output logic [63:0]              out_pc,
    output logic [63:0]              out_inst,
    output logic [1:0]               out_pred_taken,
    output logic [63:0]              out_pred_addr,
    output logic [1:0]               out_excp,
    output logic [13:0]              out_excp_cause,
    output logic [$clog2(DEPTH):0]   count
`ifdef INST_QUEUE_PERF_EN
    ,
    output logic [31:0]              full_stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Entry storage; not reset, contents only matter between head and tail.
    logic [31:0] r_pc        [DEPTH];
    logic [31:0] r_inst      [DEPTH];
    logic        r_pred_taken[DEPTH];
    logic [31:0] r_pred_addr [DEPTH];
    logic        r_excp      [DEPTH];
    logic [6:0]  r_excp_cause[DEPTH];

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_enq_ok;
    logic          w_enq_two;
    logic [CW-1:0] w_enq_n;
    logic [CW-1:0] w_deq_req;
    logic [CW-1:0] w_deq_n;
    logic [AW-1:0] w_tail_p1;
    logic [AW-1:0] w_head_p1;

    // Readiness looks only at the registered count: a same-cycle dequeue is
    // not credited, which keeps in_ready off the decode timing path.
    assign in_ready  = (r_count <= CW'(DEPTH - 2));

    // in_valid = 10 is not a legal fetch pattern and writes nothing.
    assign w_enq_ok  = in_ready && ((in_valid == 2'b01) || (in_valid == 2'b11));
    assign w_enq_two = in_ready && (in_valid == 2'b11);

    // Pointers are AW bits wide, so +1 wraps modulo DEPTH for free.
    assign w_tail_p1 = r_tail + AW'(1);
    assign w_head_p1 = r_head + AW'(1);

    always_comb begin
        w_enq_n = '0;
        if (w_enq_ok) begin
            w_enq_n = w_enq_two ? CW'(2) : CW'(1);
        end
    end

    always_comb begin
        w_deq_req = '0;
        case (deq_num)
            2'd0:    w_deq_req = CW'(0);
            2'd1:    w_deq_req = CW'(1);
            default: w_deq_req = CW'(2);
        endcase
        // Never consume more than is present.
        w_deq_n = (w_deq_req > r_count) ? r_count : w_deq_req;
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (w_enq_ok) begin
            r_pc        [r_tail] <= in_pc[31:0];
            r_inst      [r_tail] <= in_inst[31:0];
            r_pred_taken[r_tail] <= in_pred_taken[0];
            r_pred_addr [r_tail] <= in_pred_addr[31:0];
            r_excp      [r_tail] <= in_excp[0];
            r_excp_cause[r_tail] <= in_excp_cause[6:0];
        end
        if (w_enq_two) begin
            r_pc        [w_tail_p1] <= in_pc[63:32];
            r_inst      [w_tail_p1] <= in_inst[63:32];
            r_pred_taken[w_tail_p1] <= in_pred_taken[1];
            r_pred_addr [w_tail_p1] <= in_pred_addr[63:32];
            r_excp      [w_tail_p1] <= in_excp[1];
            r_excp_cause[w_tail_p1] <= in_excp_cause[13:7];
        end
    end

    // Pointer and occupancy control; flush drops same-cycle traffic.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_deq_n);
            r_tail  <= r_tail + AW'(w_enq_n);
            r_count <= r_count + w_enq_n - w_deq_n;
        end
    end

    assign count     = r_count;
    assign out_valid = {(r_count >= CW'(2)), (r_count != '0)};

    assign out_pc         = {r_pc[w_head_p1],          r_pc[r_head]};
    assign out_inst       = {r_inst[w_head_p1],        r_inst[r_head]};
    assign out_pred_taken = {r_pred_taken[w_head_p1],  r_pred_taken[r_head]};
    assign out_pred_addr  = {r_pred_addr[w_head_p1],   r_pred_addr[r_head]};
    assign out_excp       = {r_excp[w_head_p1],        r_excp[r_head]};
    assign out_excp_cause = {r_excp_cause[w_head_p1],  r_excp_cause[r_head]};

`ifdef INST_QUEUE_PERF_EN
    logic [31:0] r_full_stall_cnt;

    // Counts refused fetch cycles; flush does not clear it, only rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full_stall_cnt <= '0;
        end else if ((in_valid != 2'b00) && !in_ready &&
                     (r_full_stall_cnt != 32'hFFFF_FFFF)) begin
            r_full_stall_cnt <= r_full_stall_cnt + 32'd1;
        end
    end

    assign full_stall_cnt = r_full_stall_cnt;
`endif

endmodule
